// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the dino game sequencer.
//   state_e    : game state encoding (IDLE=0, RUN=1, JUMP=2, DEAD=3)
//   SCREEN_W/H : visible screen size in pixels
//   MAX_SPEED  : upper bound on the cactus step per frame
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        JUMP = 2'd2,
        DEAD = 2'd3
    } state_e;

    localparam logic [9:0] SCREEN_W  = 10'd640;
    localparam logic [9:0] SCREEN_H  = 10'd480;
    localparam logic [9:0] MAX_SPEED = 10'd15;

endpackage

// File: rtl/score_bcd.sv
// score_bcd: 4-digit BCD score counter, 9999 rolls over to 0000.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (score -> 0000)
//   inc      : add one to the score this cycle
//   clear    : synchronous return to 0000 (wins over inc)
//   score    : BCD value, digit 3 in [15:12]
module score_bcd (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        clear,
    output logic [15:0] score
);

    logic [15:0] score_q;
    logic [15:0] score_inc;
    logic        carry;

    // Ripple a carry up from digit 0; a digit at 9 becomes 0 and passes the carry on.
    always_comb begin
        score_inc = score_q;
        carry     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (score_q[4*i +: 4] == 4'd9) begin
                    score_inc[4*i +: 4] = 4'd0;
                end else begin
                    score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score_q <= 16'h0000;
        end else if (clear) begin
            score_q <= 16'h0000;
        end else if (inc) begin
            score_q <= score_inc;
        end
    end

    assign score = score_q;

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: per-frame sequencer for the dino VGA game. Advances dino and cactus
// once per frame (at v_cnt==TICK_LINE, h_cnt==0), tracks score and detects
// dino/cactus overlap from the sprite layer signals.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   h_cnt, v_cnt     : current pixel column / line
//   valid            : visible-area flag
//   black_dino       : dino layer pixel on
//   black_cactus     : cactus layer pixel on
//   jump_pulse       : one-cycle debounced jump button pulse
//   dino_y, cactus_x : dino top edge y, cactus left edge x
//   score            : 4-digit BCD score
//   state            : IDLE=0, RUN=1, JUMP=2, DEAD=3
//   game_over        : high while DEAD
// Optional build macro GAME_SPEEDUP_EN: cactus step grows with the score tens digit.
module game_ctrl
    import game_pkg::*;
#(
    parameter logic [9:0] GROUND_Y     = 10'd400,
    parameter logic [6:0] JUMP_V0      = 7'd12,
    parameter logic [6:0] GRAVITY      = 7'd1,
    parameter logic [9:0] CACTUS_X0    = 10'd640,
    parameter logic [9:0] CACTUS_SPEED = 10'd4,
    parameter logic [9:0] TICK_LINE    = 10'd480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        valid,
    input  logic        black_dino,
    input  logic        black_cactus,
    input  logic        jump_pulse,
    output logic [9:0]  dino_y,
    output logic [9:0]  cactus_x,
    output logic [15:0] score,
    output logic [1:0]  state,
    output logic        game_over
);

    state_e             state_q;
    logic [9:0]         dino_y_q;
    logic [9:0]         cactus_x_q;
    logic signed [6:0]  vel_q;
    logic               hit_q;
    logic               cond_q;
    logic               game_over_q;

    logic               cond;
    logic               tick;
    logic               playing;
    logic               hit_now;
    logic               hit_eff;
    logic [9:0]         speed;
    logic               respawn;
    logic [9:0]         cactus_next;
    logic signed [10:0] next_y;
    logic               landed;
    logic               score_inc;
    logic               score_clr;

    // Edge-detect the tick line so a slow pixel clock still yields one pulse per frame.
    assign cond = (v_cnt == TICK_LINE) && (h_cnt == 10'd0);
    assign tick = cond && !cond_q;

    assign playing = (state_q == RUN) || (state_q == JUMP);
    assign hit_now = playing && valid && black_dino && black_cactus;
    // A collision in the tick cycle itself still counts for that tick.
    assign hit_eff = hit_q || hit_now;

`ifdef GAME_SPEEDUP_EN
    logic [10:0] speed_sum;
    assign speed_sum = {1'b0, CACTUS_SPEED} + {7'd0, score[7:4]};
    assign speed     = (speed_sum > {1'b0, MAX_SPEED}) ? MAX_SPEED : speed_sum[9:0];
`else
    assign speed = CACTUS_SPEED;
`endif

    assign respawn     = cactus_x_q < speed;
    assign cactus_next = respawn ? CACTUS_X0 : (cactus_x_q - speed);

    assign next_y = $signed({1'b0, dino_y_q}) - $signed({{4{vel_q[6]}}, vel_q});
    assign landed = next_y >= $signed({1'b0, GROUND_Y});

    assign score_inc = tick && playing && !hit_eff && respawn;
    assign score_clr = (state_q == DEAD) && jump_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dino_y_q    <= GROUND_Y;
            cactus_x_q  <= CACTUS_X0;
            vel_q       <= 7'sd0;
            hit_q       <= 1'b0;
            cond_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            cond_q <= cond;
            if (hit_now) begin
                hit_q <= 1'b1;
            end
            // Each tick consumes the collision flag.
            if (tick) begin
                hit_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (jump_pulse) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (tick && hit_eff) begin
                        state_q     <= DEAD;
                        game_over_q <= 1'b1;
                    end else begin
                        if (tick) begin
                            cactus_x_q <= cactus_next;
                        end
                        if (jump_pulse) begin
                            state_q <= JUMP;
                            vel_q   <= JUMP_V0;
                        end
                    end
                end
                JUMP: begin
                    if (tick) begin
                        if (hit_eff) begin
                            state_q     <= DEAD;
                            game_over_q <= 1'b1;
                        end else begin
                            cactus_x_q <= cactus_next;
                            if (landed) begin
                                dino_y_q <= GROUND_Y;
                                vel_q    <= 7'sd0;
                                state_q  <= RUN;
                            end else begin
                                dino_y_q <= next_y[9:0];
                                vel_q    <= vel_q - GRAVITY;
                            end
                        end
                    end
                end
                DEAD: begin
                    if (jump_pulse) begin
                        state_q     <= IDLE;
                        game_over_q <= 1'b0;
                        dino_y_q    <= GROUND_Y;
                        cactus_x_q  <= CACTUS_X0;
                        vel_q       <= 7'sd0;
                        hit_q       <= 1'b0;
                    end
                end
            endcase
        end
    end

    score_bcd u_score (
        .clk   (clk),
        .rst   (rst),
        .inc   (score_inc),
        .clear (score_clr),
        .score (score)
    );

    assign dino_y    = dino_y_q;
    assign cactus_x  = cactus_x_q;
    assign state     = state_q;
    assign game_over = game_over_q;

endmodule
